// File: rtl/smartwatch_mode_ctrl.sv
// Smartwatch mode/edit controller: button edge detection, six-state mode FSM,
// time-set, alarm and stopwatch registers. Optional blink via SMARTWATCH_BLINK_EN.
module smartwatch_mode_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       clr_btn,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic [4:0] hours_initial,
  output logic [5:0] minutes_initial,
  output logic [5:0] seconds_initial,
  output logic       load_time,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm_enable,
  output logic       start_stopwatch,
  output logic       reset_stopwatch,
  output logic [2:0] mode,
  output logic       blink
);

  typedef enum logic [2:0] {
    CLOCK   = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    AL_HR   = 3'd3,
    AL_MIN  = 3'd4,
    STOPW   = 3'd5
  } state_t;

  state_t     state_reg, state_next;
  logic       mode_prev_reg, inc_prev_reg, clr_prev_reg;
  logic [4:0] hours_reg, hours_next;
  logic [5:0] minutes_reg, minutes_next;
  logic [4:0] alarm_hours_reg, alarm_hours_next;
  logic [5:0] alarm_minutes_reg, alarm_minutes_next;
  logic       alarm_enable_reg, alarm_enable_next;
  logic       start_sw_reg, start_sw_next;
  logic       reset_sw_reg, reset_sw_next;
  logic       load_time_reg, load_time_next;
  logic       blink_reg, blink_next;

  logic mode_ev, inc_ev, clr_ev, inc_act, clr_act;

  assign mode_ev = mode_btn & ~mode_prev_reg;
  assign inc_ev  = inc_btn  & ~inc_prev_reg;
  assign clr_ev  = clr_btn  & ~clr_prev_reg;
  // A mode event swallows any inc/clr event arriving in the same cycle.
  assign inc_act = inc_ev & ~mode_ev;
  assign clr_act = clr_ev & ~mode_ev;

  always_comb begin
    state_next         = state_reg;
    hours_next         = hours_reg;
    minutes_next       = minutes_reg;
    alarm_hours_next   = alarm_hours_reg;
    alarm_minutes_next = alarm_minutes_reg;
    alarm_enable_next  = alarm_enable_reg;
    start_sw_next      = start_sw_reg;
    reset_sw_next      = 1'b0;
    load_time_next     = 1'b0;

    case (state_reg)
      CLOCK: begin
        if (mode_ev) begin
          state_next   = SET_HR;
          hours_next   = cur_hour;
          minutes_next = cur_minute;
        end else if (inc_act) begin
          alarm_enable_next = ~alarm_enable_reg;
        end
      end
      SET_HR: begin
        if (mode_ev)
          state_next = SET_MIN;
        else if (inc_act)
          hours_next = (hours_reg >= 5'd23) ? 5'd0 : hours_reg + 5'd1;
      end
      SET_MIN: begin
        if (mode_ev) begin
          state_next     = AL_HR;
          load_time_next = 1'b1;
        end else if (inc_act) begin
          minutes_next = (minutes_reg >= 6'd59) ? 6'd0 : minutes_reg + 6'd1;
        end
      end
      AL_HR: begin
        if (mode_ev)
          state_next = AL_MIN;
        else if (inc_act)
          alarm_hours_next = (alarm_hours_reg >= 5'd23) ? 5'd0 : alarm_hours_reg + 5'd1;
      end
      AL_MIN: begin
        if (mode_ev)
          state_next = STOPW;
        else if (inc_act)
          alarm_minutes_next = (alarm_minutes_reg >= 6'd59) ? 6'd0 : alarm_minutes_reg + 6'd1;
      end
      STOPW: begin
        if (mode_ev) begin
          state_next = CLOCK;
        end else begin
          if (inc_act)
            start_sw_next = ~start_sw_reg;
          // clear overrides a simultaneous toggle
          if (clr_act) begin
            reset_sw_next = 1'b1;
            start_sw_next = 1'b0;
          end
        end
      end
      default: state_next = CLOCK;
    endcase
  end

`ifdef SMARTWATCH_BLINK_EN
  always_comb begin
    blink_next = blink_reg;
    if (state_next == CLOCK || state_next == STOPW)
      blink_next = 1'b0;
    else if (tick)
      blink_next = ~blink_reg;
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign blink_next  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= CLOCK;
      mode_prev_reg     <= 1'b0;
      inc_prev_reg      <= 1'b0;
      clr_prev_reg      <= 1'b0;
      hours_reg         <= 5'd0;
      minutes_reg       <= 6'd0;
      alarm_hours_reg   <= 5'd0;
      alarm_minutes_reg <= 6'd0;
      alarm_enable_reg  <= 1'b0;
      start_sw_reg      <= 1'b0;
      reset_sw_reg      <= 1'b0;
      load_time_reg     <= 1'b0;
      blink_reg         <= 1'b0;
    end else begin
      state_reg         <= state_next;
      mode_prev_reg     <= mode_btn;
      inc_prev_reg      <= inc_btn;
      clr_prev_reg      <= clr_btn;
      hours_reg         <= hours_next;
      minutes_reg       <= minutes_next;
      alarm_hours_reg   <= alarm_hours_next;
      alarm_minutes_reg <= alarm_minutes_next;
      alarm_enable_reg  <= alarm_enable_next;
      start_sw_reg      <= start_sw_next;
      reset_sw_reg      <= reset_sw_next;
      load_time_reg     <= load_time_next;
      blink_reg         <= blink_next;
    end
  end

  assign mode            = state_reg;
  assign hours_initial   = hours_reg;
  assign minutes_initial = minutes_reg;
  assign seconds_initial = 6'd0;
  assign load_time       = load_time_reg;
  assign alarm_hours     = alarm_hours_reg;
  assign alarm_minutes   = alarm_minutes_reg;
  assign alarm_enable    = alarm_enable_reg;
  assign start_stopwatch = start_sw_reg;
  assign reset_stopwatch = reset_sw_reg;
  assign blink           = blink_reg;

endmodule

// File: tb/tb_smartwatch_mode_ctrl.sv
// Directed scoreboard bench for smartwatch_mode_ctrl; expected outputs are queued
// per driven cycle and compared one cycle later. Honours SMARTWATCH_BLINK_EN.
module tb_smartwatch_mode_ctrl;

`ifdef SMARTWATCH_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam int MODE = 0, INC = 1, CLR = 2;

  logic       clk = 1'b0;
  logic       reset, tick, mode_btn, inc_btn, clr_btn;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute;
  logic [4:0] hours_initial, alarm_hours;
  logic [5:0] minutes_initial, seconds_initial, alarm_minutes;
  logic       load_time, alarm_enable, start_stopwatch, reset_stopwatch, blink;
  logic [2:0] mode;

  smartwatch_mode_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick),
    .mode_btn(mode_btn), .inc_btn(inc_btn), .clr_btn(clr_btn),
    .cur_hour(cur_hour), .cur_minute(cur_minute),
    .hours_initial(hours_initial), .minutes_initial(minutes_initial),
    .seconds_initial(seconds_initial), .load_time(load_time),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_enable(alarm_enable), .start_stopwatch(start_stopwatch),
    .reset_stopwatch(reset_stopwatch), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] mode;
    logic [4:0] hi;
    logic [5:0] mi;
    logic       lt;
    logic [4:0] ah;
    logic [5:0] am;
    logic       ae, ss, rs, bl;
  } exp_t;

  exp_t exp_cur;
  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check_one(input string tag, input string field,
                           input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic clear_exp();
    exp_cur.mode = 3'd0; exp_cur.hi = 5'd0; exp_cur.mi = 6'd0; exp_cur.lt = 1'b0;
    exp_cur.ah = 5'd0; exp_cur.am = 6'd0; exp_cur.ae = 1'b0; exp_cur.ss = 1'b0;
    exp_cur.rs = 1'b0; exp_cur.bl = 1'b0;
  endtask

  // Inputs are already driven (at negedge); queue the expectation, clock, compare.
  task automatic cycle(input string tag);
    exp_t e;
    exp_cur.tag = tag;
    sb_q.push_back(exp_cur);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_one(e.tag, "mode", {5'd0, mode}, {5'd0, e.mode});
    check_one(e.tag, "hours_initial", {3'd0, hours_initial}, {3'd0, e.hi});
    check_one(e.tag, "minutes_initial", {2'd0, minutes_initial}, {2'd0, e.mi});
    check_one(e.tag, "seconds_initial", {2'd0, seconds_initial}, 8'd0);
    check_one(e.tag, "load_time", {7'd0, load_time}, {7'd0, e.lt});
    check_one(e.tag, "alarm_hours", {3'd0, alarm_hours}, {3'd0, e.ah});
    check_one(e.tag, "alarm_minutes", {2'd0, alarm_minutes}, {2'd0, e.am});
    check_one(e.tag, "alarm_enable", {7'd0, alarm_enable}, {7'd0, e.ae});
    check_one(e.tag, "start_stopwatch", {7'd0, start_stopwatch}, {7'd0, e.ss});
    check_one(e.tag, "reset_stopwatch", {7'd0, reset_stopwatch}, {7'd0, e.rs});
    check_one(e.tag, "blink", {7'd0, blink}, {7'd0, e.bl});
    $display("cycle %s mode=%0d h=%0d m=%0d lt=%0b ah=%0d am=%0d ae=%0b ss=%0b rs=%0b bl=%0b",
             e.tag, mode, hours_initial, minutes_initial, load_time, alarm_hours,
             alarm_minutes, alarm_enable, start_stopwatch, reset_stopwatch, blink);
    @(negedge clk);
  endtask

  // Caller sets exp_cur for the edge cycle; release cycle drops the pulses.
  task automatic press(input int btn, input string tag);
    case (btn)
      MODE:    mode_btn = 1'b1;
      INC:     inc_btn  = 1'b1;
      default: clr_btn  = 1'b1;
    endcase
    cycle(tag);
    mode_btn = 1'b0; inc_btn = 1'b0; clr_btn = 1'b0;
    exp_cur.lt = 1'b0;
    exp_cur.rs = 1'b0;
    cycle({tag, "_rel"});
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; clr_btn = 1'b0;
    cur_hour = 5'd14; cur_minute = 6'd37;
    clear_exp();
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    reset = 1'b1;
    cycle("idle");

    exp_cur.ae = 1'b1; press(INC, "clk_inc_on");
    exp_cur.ae = 1'b0; press(INC, "clk_inc_off");
    press(CLR, "clk_clr_ignored");
    tick = 1'b1; cycle("clk_tick_no_blink"); tick = 1'b0;

    exp_cur.mode = 3'd1; exp_cur.hi = 5'd14; exp_cur.mi = 6'd37;
    press(MODE, "to_set_hr");

    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      if (BLINK) exp_cur.bl = ~exp_cur.bl;
      cycle("set_hr_tick");
    end
    tick = 1'b0;

    for (int i = 0; i < 9; i++) begin
      exp_cur.hi = exp_cur.hi + 5'd1;
      press(INC, "set_hr_inc");
    end
    exp_cur.hi = 5'd0; press(INC, "set_hr_wrap");

    exp_cur.mode = 3'd2; press(MODE, "to_set_min");
    for (int i = 0; i < 23; i++) begin
      exp_cur.mi = (exp_cur.mi == 6'd59) ? 6'd0 : exp_cur.mi + 6'd1;
      press(INC, "set_min_inc");
    end

    exp_cur.mode = 3'd3; exp_cur.lt = 1'b1; press(MODE, "load_time");

    for (int i = 0; i < 5; i++) begin
      exp_cur.ah = exp_cur.ah + 5'd1;
      press(INC, "al_hr_inc");
    end
    mode_btn = 1'b1; inc_btn = 1'b1; exp_cur.mode = 3'd4;
    cycle("mode_inc_same");
    mode_btn = 1'b0; inc_btn = 1'b0;
    cycle("mode_inc_same_rel");

    inc_btn = 1'b1; exp_cur.am = 6'd1;
    for (int i = 0; i < 100; i++) cycle("al_min_hold");
    inc_btn = 1'b0;
    cycle("al_min_release");

    tick = 1'b1;
    if (BLINK) exp_cur.bl = ~exp_cur.bl;
    cycle("al_min_tick");
    tick = 1'b0;

    exp_cur.mode = 3'd5; exp_cur.bl = 1'b0; press(MODE, "to_stopw");
    tick = 1'b1; cycle("stopw_tick_no_blink"); tick = 1'b0;
    exp_cur.ss = 1'b1; press(INC, "stopw_start");
    exp_cur.ss = 1'b0; exp_cur.rs = 1'b1; press(CLR, "stopw_clr");
    exp_cur.ss = 1'b1; press(INC, "stopw_restart");
    exp_cur.mode = 3'd0; press(MODE, "to_clock_ss_held");
    press(CLR, "clk_clr_ignored2");

    exp_cur.mode = 3'd1; exp_cur.hi = 5'd14; exp_cur.mi = 6'd37; press(MODE, "edit2_set_hr");
    exp_cur.mode = 3'd2; press(MODE, "edit2_set_min");
    exp_cur.mi = 6'd38; press(INC, "edit2_inc");

    reset = 1'b0; mode_btn = 1'b1; clear_exp();
    cycle("rst_mid_edit");
    mode_btn = 1'b0;
    cycle("rst_hold");
    reset = 1'b1;
    cycle("after_rst");
    cycle("after_rst2");

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smartwatch_mode_ctrl.md
SMARTWATCH_MODE_CTRL -- requirements
Module: smartwatch_mode_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; these are the only clock and reset ports.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous active-low reset; 0 on a rising clk edge resets all state.
REQ-004 tick  input  1  one-cycle half-second strobe; drives blink only.
REQ-005 mode_btn, inc_btn, clr_btn  input  1 each  debounced, clk-synchronous button levels.
REQ-006 cur_hour  input  5  live hour from the digital watch, 0..23.
REQ-007 cur_minute  input  6  live minute from the digital watch, 0..59.
REQ-008 hours_initial  output  5  time-set hour value.
REQ-009 minutes_initial  output  6  time-set minute value.
REQ-010 seconds_initial  output  6  time-set second value; constant 0.
REQ-011 load_time  output  1  one-cycle pulse; commits the *_initial values.
REQ-012 alarm_hours  output  5  alarm hour, 0..23.
REQ-013 alarm_minutes  output  6  alarm minute, 0..59.
REQ-014 alarm_enable  output  1  alarm armed.
REQ-015 start_stopwatch  output  1  stopwatch run level.
REQ-016 reset_stopwatch  output  1  one-cycle stopwatch clear pulse.
REQ-017 mode  output  3  current state encoding.
REQ-018 blink  output  1  flash enable for the field being edited.

Function
REQ-019 Each button SHALL be rising-edge detected against its registered previous value; one press SHALL produce exactly one event, and a held button SHALL produce no further events.
REQ-020 The FSM SHALL have six states, encoded on mode as CLOCK=0, SET_HR=1, SET_MIN=2, AL_HR=3, AL_MIN=4, STOPW=5.
REQ-021 A mode event SHALL advance the state CLOCK->SET_HR->SET_MIN->AL_HR->AL_MIN->STOPW->CLOCK; encodings 6 and 7 SHALL go to CLOCK on the next cycle.
REQ-022 On the CLOCK->SET_HR transition, hours_initial and minutes_initial SHALL be loaded from cur_hour and cur_minute in the same cycle.
REQ-023 In SET_HR, an inc event SHALL add 1 to hours_initial, wrapping 23->0.
REQ-024 In SET_MIN, an inc event SHALL add 1 to minutes_initial, wrapping 59->0.
REQ-025 On the SET_MIN->AL_HR transition, load_time SHALL be 1 for exactly the cycle after the mode event; *_initial SHALL hold their values through that cycle.
REQ-026 In AL_HR, an inc event SHALL add 1 to alarm_hours, wrapping 23->0.
REQ-027 In AL_MIN, an inc event SHALL add 1 to alarm_minutes, wrapping 59->0.
REQ-028 In CLOCK, an inc event SHALL toggle alarm_enable.
REQ-029 In STOPW, an inc event SHALL toggle start_stopwatch.
REQ-030 In STOPW, a clr event SHALL pulse reset_stopwatch high for one cycle and clear start_stopwatch.
REQ-031 start_stopwatch SHALL hold its value when the state leaves STOPW.
REQ-032 clr events outside STOPW SHALL be ignored.
REQ-033 If a mode event and an inc or clr event occur in the same cycle, the mode event SHALL win and the other event SHALL be discarded.
REQ-034 Every output SHALL be registered, with one-cycle latency from the button edge cycle.

Reset
REQ-035 With reset=0 at a clock edge, the state SHALL go to CLOCK and all *_initial, alarm_*, alarm_enable, start_stopwatch and blink SHALL be 0.
REQ-036 With reset=0 at a clock edge, load_time and reset_stopwatch SHALL be 0 and the edge-detect registers SHALL be 0.
REQ-037 A reset asserted mid-edit SHALL discard the edit; load_time SHALL NOT pulse.

Configuration
REQ-038 With macro SMARTWATCH_BLINK_EN defined, blink SHALL toggle on each tick while in SET_HR, SET_MIN, AL_HR or AL_MIN.
REQ-039 With SMARTWATCH_BLINK_EN defined, blink SHALL be forced to 0 on the cycle the state enters CLOCK or STOPW.
REQ-040 With SMARTWATCH_BLINK_EN undefined, blink SHALL be tied to 0, tick SHALL be unused, and all other behaviour SHALL be identical.

Verification
REQ-041 Reset, then 1 mode press with cur_hour=14 and cur_minute=37 -> mode=1, hours_initial=14, minutes_initial=37.
REQ-042 From SET_HR with hour=23, 1 inc press -> hour=0; 1 mode press, 23 inc presses from minute=37 -> minute=0; 1 mode press -> load_time high exactly 1 cycle with 0:00, then mode=3.
REQ-043 In STOPW, inc press -> start_stopwatch=1; clr press -> reset_stopwatch pulse of 1 cycle, start_stopwatch=0.
REQ-044 Mode and inc rising in the same cycle in AL_HR with alarm_hours=5 -> mode=4, alarm_hours stays 5.
REQ-045 Hold inc high for 100 cycles in AL_MIN from 0 -> alarm_minutes=1.
REQ-046 Assert reset while in SET_MIN -> mode=0, load_time never pulses; with SMARTWATCH_BLINK_EN, 4 ticks in SET_HR -> blink toggles 4 times.
